osd_trace_depacketization: RTL and testbench

- Receive end of the trace packet protocol: consumes DII event packets from the debug interconnect and reassembles them into one WIDTH-bit trace sample or one overflow record each.
- Hands each result to a downstream valid/ready consumer, such as a host-side trace sink or a loopback checker in the trace subsystem.
- Rejects malformed packets and flags them; never emits a partial sample.

---
 rtl/dii_package.sv | 10 +
 rtl/osd_trace_package.sv | 15 +
 rtl/osd_trace_word_assembler.sv | 43 ++++
 rtl/osd_trace_depacketization.sv | 117 +++++++++++
 tb/tb_osd_trace_depacketization.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_package.sv
// rtl/dii_package.sv - debug interconnect flit type
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_trace_package.sv
// rtl/osd_trace_package.sv - trace packet type codes, flags fields and word-count helper
package osd_trace_package;

    localparam logic [1:0] TYPE_EVENT         = 2'b10;
    localparam logic [3:0] TYPE_SUB_TRACE     = 4'd0;
    localparam logic [3:0] TYPE_SUB_OVERFLOW  = 4'd5;
    localparam int         FLAGS_TYPE_LSB     = 14;
    localparam int         FLAGS_TYPE_SUB_LSB = 10;

    // Number of 16-bit payload words carrying a WIDTH-bit sample.
    function automatic int nw(input int width);
        return (width + 15) / 16;
    endfunction

endpackage

// File: rtl/osd_trace_word_assembler.sv
// rtl/osd_trace_word_assembler.sv - payload word counter and slice-write sample register
module osd_trace_word_assembler
    import osd_trace_package::*;
#(
    parameter int  WIDTH = 165,
    localparam int NW    = nw(WIDTH),
    localparam int CW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [15:0]      wr_data,
    output logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] assembled
);

    logic [WIDTH-1:0] data_q;

    // Bits of the last word beyond WIDTH have no storage and are simply dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            data_q <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (cnt == CW'(b / 16)) data_q[b] <= wr_data[b % 16];
            end
            cnt <= cnt + CW'(1);
        end
    end

    // Register contents with the word being written this cycle merged in.
    always_comb begin
        assembled = data_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (wr_en && cnt == CW'(b / 16)) assembled[b] = wr_data[b % 16];
        end
    end

endmodule

// File: rtl/osd_trace_depacketization.sv
// rtl/osd_trace_depacketization.sv - reassembles DII event packets into trace samples or overflow records
module osd_trace_depacketization
    import osd_trace_package::*, dii_package::*;
#(
    parameter int WIDTH = 165
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit          debug_in,
    output logic             debug_in_ready,
    output logic [WIDTH-1:0] trace_data,
    output logic             trace_overflow,
    output logic [15:0]      trace_src,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic             proto_err
);

    localparam int NW = nw(WIDTH);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [2:0] ST_DEST    = 3'd0;
    localparam logic [2:0] ST_SRC     = 3'd1;
    localparam logic [2:0] ST_FLAGS   = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    logic [2:0]       state;
    logic             is_ovf;
    logic [15:0]      src_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] assembled;
    logic             accept;
    logic [1:0]       flag_type;
    logic [3:0]       flag_sub;
    logic             known_kind;
    logic             final_word;

    assign debug_in_ready = rst && (state != ST_HOLD);
    assign trace_valid    = (state == ST_HOLD);
    assign accept         = debug_in.valid && debug_in_ready;

    assign flag_type  = debug_in.data[FLAGS_TYPE_LSB +: 2];
    assign flag_sub   = debug_in.data[FLAGS_TYPE_SUB_LSB +: 4];
    assign known_kind = (flag_type == TYPE_EVENT) &&
                        (flag_sub == TYPE_SUB_TRACE || flag_sub == TYPE_SUB_OVERFLOW);
    assign final_word = is_ovf ? (cnt == '0) : (cnt == CW'(NW - 1));

    osd_trace_word_assembler #(.WIDTH(WIDTH)) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept && state == ST_FLAGS),
        .wr_en     (accept && state == ST_PAYLOAD),
        .wr_data   (debug_in.data),
        .cnt       (cnt),
        .assembled (assembled)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_DEST;
            is_ovf         <= 1'b0;
            src_q          <= '0;
            trace_data     <= '0;
            trace_overflow <= 1'b0;
            trace_src      <= '0;
            proto_err      <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                ST_DEST: if (accept) begin
                    if (debug_in.last) proto_err <= 1'b1;
                    else               state     <= ST_SRC;
                end
                ST_SRC: if (accept) begin
                    src_q <= debug_in.data;
                    if (debug_in.last) begin
                        proto_err <= 1'b1;
                        state     <= ST_DEST;
                    end else begin
                        state <= ST_FLAGS;
                    end
                end
                ST_FLAGS: if (accept) begin
                    is_ovf <= (flag_sub == TYPE_SUB_OVERFLOW);
                    if (debug_in.last) begin
                        proto_err <= 1'b1;
                        state     <= ST_DEST;
                    end else if (known_kind) begin
                        state <= ST_PAYLOAD;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_PAYLOAD: if (accept) begin
                    if (final_word && debug_in.last) begin
                        trace_src      <= src_q;
                        trace_overflow <= is_ovf;
                        trace_data     <= is_ovf ? WIDTH'(debug_in.data) : assembled;
                        state          <= ST_HOLD;
                    end else if (final_word) begin
                        proto_err <= 1'b1;
                        state     <= ST_DROP;
                    end else if (debug_in.last) begin
                        proto_err <= 1'b1;
                        state     <= ST_DEST;
                    end
                end
                ST_DROP: if (accept && debug_in.last) state <= ST_DEST;
                ST_HOLD: if (trace_ready) state <= ST_DEST;
                default: state <= ST_DEST;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// tb/tb_osd_trace_depacketization.sv - randomized self-checking bench for osd_trace_depacketization
module tb_osd_trace_depacketization;
    import dii_package::*;

    localparam int WIDTH = 165;
    localparam int NW    = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    dii_flit          debug_in;
    logic             debug_in_ready;
    logic [WIDTH-1:0] trace_data;
    logic             trace_overflow;
    logic [15:0]      trace_src;
    logic             trace_valid;
    logic             trace_ready = 1'b1;
    logic             proto_err;

    always #5 clk = ~clk;

    osd_trace_depacketization #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .debug_in       (debug_in),
        .debug_in_ready (debug_in_ready),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .trace_src      (trace_src),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .proto_err      (proto_err)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ovf;
        logic [15:0]      src;
    } rec_t;

    int          checks = 0;
    int          errors = 0;
    rec_t        exp_q[$];
    int          exp_err = 0;
    int          seen_err = 0;
    int          seen_rec = 0;
    logic [15:0] pkt[$];
    int          ready_mode = 0;
    bit          gaps = 0;
    bit          hold_prev = 0;
    rec_t        held;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: classify a whole packet from its word list.
    task automatic expect_pkt();
        int                n;
        int                want;
        logic [15:0]       flags;
        logic [NW*16-1:0]  full;
        rec_t              r;
        n = pkt.size();
        if (n <= 3) begin
            exp_err++;
            return;
        end
        flags = pkt[2];
        if (flags[15:14] != 2'b10 || (flags[13:10] != 4'd0 && flags[13:10] != 4'd5)) return;
        want = (flags[13:10] == 4'd0) ? NW : 1;
        if (n - 3 != want) begin
            exp_err++;
            return;
        end
        full = '0;
        for (int i = 0; i < want; i++) full[16*i +: 16] = pkt[3+i];
        r.data = (want == 1) ? WIDTH'(pkt[3]) : full[WIDTH-1:0];
        r.ovf  = (want == 1);
        r.src  = pkt[1];
        exp_q.push_back(r);
    endtask

    task automatic build(input logic [15:0] flags, input int npay);
        pkt = {};
        pkt.push_back(16'($urandom));
        pkt.push_back(16'($urandom));
        pkt.push_back(flags);
        for (int i = 0; i < npay; i++) pkt.push_back(16'($urandom));
    endtask

    task automatic send_pkt(input int nflits);
        int tmo;
        for (int i = 0; i < nflits; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                debug_in.valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            debug_in.valid = 1'b1;
            debug_in.data  = pkt[i];
            debug_in.last  = (i == pkt.size() - 1);
            tmo = 0;
            while (!debug_in_ready && tmo < 200) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 200) begin
                check("accept_timeout", 1, 0);
                debug_in.valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        #1 debug_in.valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        repeat (3) @(negedge clk);
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Output monitor and ready driver.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (proto_err) seen_err++;
            case (ready_mode)
                0:       trace_ready = 1'b1;
                1:       trace_ready = 1'($urandom_range(0, 1));
                default: trace_ready = 1'b0;
            endcase
            if (trace_valid && hold_prev) begin
                check("stable_data", trace_data, held.data);
                check("stable_ovf", trace_overflow, held.ovf);
                check("stable_src", trace_src, held.src);
            end
            if (trace_valid) begin
                if (trace_ready) begin
                    seen_rec++;
                    hold_prev = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_record", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        check("rec_data", trace_data, r.data);
                        check("rec_ovf", trace_overflow, r.ovf);
                        check("rec_src", trace_src, r.src);
                    end
                end else begin
                    hold_prev      = 1;
                    held.data      = trace_data;
                    held.ovf       = trace_overflow;
                    held.src       = trace_src;
                end
            end else begin
                hold_prev = 0;
            end
        end
    end

    initial begin
        int e0;
        int r0;
        rec_t saved;
        debug_in = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", debug_in_ready, 0);
        check("rst_valid", trace_valid, 0);
        check("rst_err", proto_err, 0);
        check("rst_data", trace_data, 0);
        check("rst_src", trace_src, 0);
        check("rst_ovf", trace_overflow, 0);
        rst = 1'b1;
        #1 check("ready_after_rst", debug_in_ready, 1);

        // Directed sample: payload 1..11
        pkt = {16'h0000, 16'h0005, 16'h8000};
        for (int i = 1; i <= NW; i++) pkt.push_back(16'(i));
        expect_pkt();
        send_pkt(pkt.size());
        check("t1_latency_valid", trace_valid, 1);
        check("t1_src", trace_src, 16'h0005);
        check("t1_ovf", trace_overflow, 0);
        check("t1_lo", trace_data[15:0], 16'h0001);
        check("t1_hi", trace_data[164:160], 5'h0B);
        drain();

        // Directed overflow record
        pkt = {16'h0000, 16'h0007, 16'h9400, 16'h0023};
        expect_pkt();
        send_pkt(pkt.size());
        check("t2_ovf", trace_overflow, 1);
        check("t2_data", trace_data, 16'h0023);
        drain();
        check("t2_err", seen_err, exp_err);

        // Back-pressure with a second packet waiting
        r0 = seen_rec;
        ready_mode = 2;
        build(16'h8000, NW);
        expect_pkt();
        send_pkt(pkt.size());
        saved.data = trace_data;
        build(16'h8000, NW);
        expect_pkt();
        fork
            send_pkt(pkt.size());
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_ready", debug_in_ready, 0);
                    check("bp_valid", trace_valid, 1);
                    check("bp_data", trace_data, saved.data);
                end
                ready_mode = 0;
            end
        join
        drain();
        check("bp_records", seen_rec - r0, 2);

        // Short, long, then good
        e0 = seen_err;
        r0 = seen_rec;
        build(16'h8000, 5);
        expect_pkt();
        send_pkt(pkt.size());
        drain();
        check("short_err", seen_err - e0, 1);
        build(16'h8000, 12);
        expect_pkt();
        send_pkt(pkt.size());
        drain();
        check("long_err", seen_err - e0, 2);
        check("bad_no_rec", seen_rec - r0, 0);
        build(16'h8000, NW);
        expect_pkt();
        send_pkt(pkt.size());
        drain();
        check("good_after_bad", seen_rec - r0, 1);

        // Unknown kind is swallowed silently
        e0 = seen_err;
        r0 = seen_rec;
        build(16'h4000, 3);
        expect_pkt();
        send_pkt(pkt.size());
        drain();
        check("unk_err", seen_err - e0, 0);
        check("unk_rec", seen_rec - r0, 0);

        // Reset mid-packet
        r0 = seen_rec;
        build(16'h8000, NW);
        send_pkt(7);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", debug_in_ready, 0);
        check("mid_rst_valid", trace_valid, 0);
        check("mid_rst_data", trace_data, 0);
        rst = 1'b1;
        build(16'h8000, NW);
        expect_pkt();
        send_pkt(pkt.size());
        drain();
        check("post_rst_rec", seen_rec - r0, 1);

        // Randomized traffic
        ready_mode = 1;
        gaps = 1;
        for (int k = 0; k < 80; k++) begin
            logic [15:0] f;
            case ($urandom_range(0, 5))
                0: build(16'h8000 | 16'($urandom_range(0, 1023)), NW);
                1: build(16'h9400 | 16'($urandom_range(0, 1023)), 1);
                2: build(16'h8000, $urandom_range(0, 14));
                3: begin
                    f = 16'($urandom);
                    if (f[15:14] == 2'b10 && (f[13:10] == 4'd0 || f[13:10] == 4'd5)) f[15:14] = 2'b01;
                    build(f, $urandom_range(0, 5));
                end
                4: begin
                    build(16'($urandom), 0);
                    repeat ($urandom_range(0, 2)) void'(pkt.pop_back());
                end
                default: build(16'h9400, $urandom_range(0, 3));
            endcase
            expect_pkt();
            send_pkt(pkt.size());
        end
        drain();
        check("rand_err_total", seen_err, exp_err);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
